// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared types and widths for the register-bank writeback unit.
// Provides the FIFO entry layout (destination register + result value) and the
// default data/register-address widths used by riscv_writeback_unit.
package riscv_wb_pkg;

  localparam int unsigned WB_XLEN   = 32;
  localparam int unsigned WB_REG_AW = 5;

  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [WB_XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/riscv_wb_fifo.sv
// riscv_wb_fifo: in-order result buffer for the writeback unit.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_entry at the tail (caller guarantees not full)
//   push_entry   entry to enqueue
//   pop          drop the head entry (caller guarantees not empty)
//   head_entry   current head (oldest) entry
//   count        occupancy, 0..DEPTH
//   rd_ptr       head index, used to walk entries oldest -> youngest
//   entries      raw storage array, exposed for the bypass search
module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head_entry,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output wb_entry_t                  entries [DEPTH]
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_entry_t       mem_q   [DEPTH];
  wb_entry_t       mem_d   [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Pointers wrap naturally; full vs. empty is told apart by the count.
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = cnt_q;
  assign rd_ptr     = rd_ptr_q;
  assign entries    = mem_q;

endmodule

// File: rtl/riscv_writeback_unit.sv
// riscv_writeback_unit: writer-side companion of the register bank.
// Accepts results over res_valid/res_ready, buffers them in order and drives
// the bank write port (w_en/r_write/w_data) at most once per cycle. Writes to
// x0 are acknowledged and dropped. A bypass lookup exposes values that have
// been accepted but not yet committed to the bank.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   res_valid/res_ready        result handshake; res_rd/res_data payload
//   w_en/r_write/w_data        registered bank write port
//   fwd_rs_a/b -> fwd_hit_a/b, fwd_data_a/b   bypass lookups (youngest wins)
//   pending_cnt                FIFO occupancy, output stage excluded
//   busy                       FIFO non-empty or a write in flight
// Build option: RISCV_WB_BYPASS_EN enables the bypass search; when undefined
// the fwd_* outputs are tied to zero and fwd_rs_* are ignored.
module riscv_writeback_unit
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = WB_XLEN,
  parameter int unsigned REG_AW = WB_REG_AW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [REG_AW-1:0]        res_rd,
  input  logic [XLEN-1:0]          res_data,
  output logic                     w_en,
  output logic [REG_AW-1:0]        r_write,
  output logic [XLEN-1:0]          w_data,
  input  logic [REG_AW-1:0]        fwd_rs_a,
  input  logic [REG_AW-1:0]        fwd_rs_b,
  output logic                     fwd_hit_a,
  output logic [XLEN-1:0]          fwd_data_a,
  output logic                     fwd_hit_b,
  output logic [XLEN-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH):0]   pending_cnt,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   fifo_rd_ptr;
  wb_entry_t       fifo_head;
  wb_entry_t       fifo_entries [DEPTH];
  wb_entry_t       push_entry;
  logic            accept, push, pop;

  logic              w_en_q, w_en_d;
  logic [REG_AW-1:0] r_write_q, r_write_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  // Ready depends only on registered occupancy, so a pop frees a slot that
  // becomes visible one cycle later.
  assign res_ready  = (fifo_cnt != CW'(DEPTH));
  assign accept     = res_valid && res_ready;
  assign push       = accept && (res_rd != '0);
  assign pop        = (fifo_cnt != '0);
  assign push_entry = '{rd: res_rd, data: res_data};

  riscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (fifo_head),
    .count      (fifo_cnt),
    .rd_ptr     (fifo_rd_ptr),
    .entries    (fifo_entries)
  );

  always_comb begin
    w_en_d    = pop;
    r_write_d = r_write_q;
    w_data_d  = w_data_q;
    if (pop) begin
      r_write_d = fifo_head.rd;
      w_data_d  = fifo_head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_en_q    <= 1'b0;
      r_write_q <= '0;
      w_data_q  <= '0;
    end else begin
      w_en_q    <= w_en_d;
      r_write_q <= r_write_d;
      w_data_q  <= w_data_d;
    end
  end

  assign w_en        = w_en_q;
  assign r_write     = r_write_q;
  assign w_data      = w_data_q;
  assign pending_cnt = fifo_cnt;
  assign busy        = (fifo_cnt != '0) || w_en_q;

`ifdef RISCV_WB_BYPASS_EN
  logic [AW-1:0] idx;

  // Candidates are scanned oldest -> youngest (output stage first, then FIFO
  // from head to tail) so a later match overrides an earlier one.
  always_comb begin
    idx        = '0;
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    if (w_en_q && (r_write_q == fwd_rs_a)) begin
      fwd_hit_a  = 1'b1;
      fwd_data_a = w_data_q;
    end
    if (w_en_q && (r_write_q == fwd_rs_b)) begin
      fwd_hit_b  = 1'b1;
      fwd_data_b = w_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = fifo_rd_ptr + AW'(i);
      if (CW'(i) < fifo_cnt) begin
        if (fifo_entries[idx].rd == fwd_rs_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = fifo_entries[idx].data;
        end
        if (fifo_entries[idx].rd == fwd_rs_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = fifo_entries[idx].data;
        end
      end
    end
    if (fwd_rs_a == '0) begin
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
    end
    if (fwd_rs_b == '0) begin
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;
    end
  end
`else
  logic unused_bypass;

  assign fwd_hit_a  = 1'b0;
  assign fwd_data_a = '0;
  assign fwd_hit_b  = 1'b0;
  assign fwd_data_b = '0;

  always_comb begin
    unused_bypass = ^{fwd_rs_a, fwd_rs_b, fifo_rd_ptr};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      unused_bypass = unused_bypass ^ (^fifo_entries[i]);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_writeback_unit.sv
module tb_riscv_writeback_unit;

`ifdef RISCV_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_rd;
  logic [31:0] res_data;
  logic        w_en;
  logic [4:0]  r_write;
  logic [31:0] w_data;
  logic [4:0]  fwd_rs_a, fwd_rs_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic [2:0]  pending_cnt;
  logic        busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  riscv_writeback_unit #(.DEPTH(4), .XLEN(32), .REG_AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .w_en        (w_en),
    .r_write     (r_write),
    .w_data      (w_data),
    .fwd_rs_a    (fwd_rs_a),
    .fwd_rs_b    (fwd_rs_b),
    .fwd_hit_a   (fwd_hit_a),
    .fwd_data_a  (fwd_data_a),
    .fwd_hit_b   (fwd_hit_b),
    .fwd_data_b  (fwd_data_b),
    .pending_cnt (pending_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Holds res_valid until a handshake edge; scoreboard entry pushed for rd!=0.
  task automatic send(input logic [4:0] rd, input logic [31:0] data);
    bit done = 1'b0;
    res_valid = 1'b1;
    res_rd    = rd;
    res_data  = data;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (res_ready === 1'b1) begin
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: data});
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    res_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a bank write must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit actual_rd=%0d actual_data=0x%0h required=none", r_write, w_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_rd", {27'd0, r_write}, {27'd0, e.rd});
        check("commit_data", w_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit idle;
    rst_n = 1'b0; res_valid = 1'b0; res_rd = '0; res_data = '0;
    fwd_rs_a = '0; fwd_rs_b = '0;
    #2;
    check("rst_w_en", {31'd0, w_en}, 32'd0);
    check("rst_pending", {29'd0, pending_cnt}, 32'd0);
    check("rst_r_write", {27'd0, r_write}, 32'd0);
    check("rst_w_data", w_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_ready", {31'd0, res_ready}, 32'd1);

    // Single write: latency and hold behaviour.
    send(5'd5, 32'h1234_5678);
    check("single_pending", {29'd0, pending_cnt}, 32'd1);
    check("single_wen_early", {31'd0, w_en}, 32'd0);
    tick();
    check("single_wen", {31'd0, w_en}, 32'd1);
    check("single_rd", {27'd0, r_write}, 32'd5);
    check("single_data", w_data, 32'h1234_5678);
    check("single_pending0", {29'd0, pending_cnt}, 32'd0);
    check("single_busy", {31'd0, busy}, 32'd1);
    tick();
    check("single_wen_off", {31'd0, w_en}, 32'd0);
    check("single_busy_off", {31'd0, busy}, 32'd0);
    check("hold_rd", {27'd0, r_write}, 32'd5);
    check("hold_data", w_data, 32'h1234_5678);

    // x0 filter.
    send(5'd0, 32'hFFFF_FFFF);
    check("x0_pending", {29'd0, pending_cnt}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("x0_wen", {31'd0, w_en}, 32'd0);
    end

    // Back-to-back stream: drain keeps pace, so occupancy stays at 1.
    for (int i = 1; i <= 5; i++) begin
      send(5'(i), 32'h100 + 32'(i));
      check("stream_pending", {29'd0, pending_cnt}, 32'd1);
    end
    idle = 1'b0;
    for (int n = 0; n < 20 && !idle; n++) begin
      tick();
      if (busy === 1'b0) idle = 1'b1;
    end
    check("stream_idle", {31'd0, idle}, 32'd1);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Bypass priority.
    fwd_rs_a = 5'd7;
    fwd_rs_b = 5'd0;
    send(5'd7, 32'hAAAA_AAAA);
    check("byp1_hit_a", {31'd0, fwd_hit_a}, {31'd0, BYP});
    check("byp1_data_a", fwd_data_a, BYP ? 32'hAAAA_AAAA : 32'd0);
    check("byp1_hit_b", {31'd0, fwd_hit_b}, 32'd0);
    send(5'd7, 32'hBBBB_BBBB);
    check("byp2_hit_a", {31'd0, fwd_hit_a}, {31'd0, BYP});
    check("byp2_data_a", fwd_data_a, BYP ? 32'hBBBB_BBBB : 32'd0);
    check("byp2_data_b", fwd_data_b, 32'd0);
    tick();
    check("byp3_wen", {31'd0, w_en}, 32'd1);
    check("byp3_hit_a", {31'd0, fwd_hit_a}, {31'd0, BYP});
    check("byp3_data_a", fwd_data_a, BYP ? 32'hBBBB_BBBB : 32'd0);
    fwd_rs_b = 5'd9;
    #1;
    check("byp3_miss_b", {31'd0, fwd_hit_b}, 32'd0);
    tick();
    check("byp4_hit_a", {31'd0, fwd_hit_a}, 32'd0);
    check("byp4_data_a", fwd_data_a, 32'd0);

    // Asynchronous reset with results in flight.
    send(5'd3, 32'h0000_0003);
    send(5'd4, 32'h0000_0004);
    send(5'd6, 32'h0000_0006);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_wen", {31'd0, w_en}, 32'd0);
    check("mid_rst_pending", {29'd0, pending_cnt}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_rd", {27'd0, r_write}, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_wen", {31'd0, w_en}, 32'd0);
    end

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
